// File: rtl/regbank_write_arbiter_pkg.sv
// Shared types and helpers for the register-bank write path.
// Holds the FSM encoding, default bank geometry and the one-hot load-select decoder.
package regbank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } wr_state_e;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int MAX_REGS     = 64;
  localparam int MAX_ADDR_W   = 6;

  // Returns a vector that is all zero when addr does not name a register in the bank.
  function automatic logic [MAX_REGS-1:0] onehot_decode(input logic [MAX_ADDR_W-1:0] addr,
                                                        input int unsigned nregs);
    logic [MAX_REGS-1:0] vec;
    vec = '0;
    if ({26'd0, addr} < nregs) vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping modulo N.
// Shared with the read-port controller.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scanning from the farthest offset down lets the nearest hit win.
  always_comb begin
    int unsigned cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int off = N; off >= 1; off--) begin
      cand = (int'(last_grant) + off) % N;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin write sequencer for a two-phase register bank: grants one requester,
// holds data and one-hot load select for HOLD_CYCLES cycles, then acknowledges.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = 2,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  localparam int GID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clkpos,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic                      busy,
  output logic [GID_W-1:0]          grant_id,
  output logic [NUM_REGS-1:0]       reg_load,
  output logic [DATA_W-1:0]         reg_din
);

  wr_state_e           state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                oor_q, oor_d;
  logic [GID_W-1:0]    last_grant_q, last_grant_d;
  logic [GID_W-1:0]    grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [NUM_REGS-1:0] reg_load_q, reg_load_d;
  logic [DATA_W-1:0]   reg_din_q, reg_din_d;

  logic                arb_valid;
  logic [GID_W-1:0]    arb_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .idx        (arb_idx)
  );

  assign sel_addr = req_addr[arb_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[arb_idx*DATA_W +: DATA_W];

  // reg_din_q doubles as the latched write data; it is only reloaded at grant.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    oor_d        = oor_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    ack_d        = '0;
    err_d        = 1'b0;
    busy_d       = busy_q;
    reg_load_d   = reg_load_q;
    reg_din_d    = reg_din_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_id_d = arb_idx;
          reg_din_d  = sel_data;
          reg_load_d = NUM_REGS'(onehot_decode(MAX_ADDR_W'(sel_addr), NUM_REGS));
          oor_d      = (32'(sel_addr) >= NUM_REGS);
          cnt_d      = 4'(HOLD_CYCLES - 1);
          busy_d     = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          reg_load_d        = '0;
          ack_d[grant_id_q] = 1'b1;
          err_d             = oor_q;
          state_d           = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        last_grant_d = grant_id_q;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        reg_load_d = '0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkpos) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      oor_q        <= 1'b0;
      last_grant_q <= GID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      reg_load_q   <= '0;
      reg_din_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      oor_q        <= oor_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      reg_load_q   <= reg_load_d;
      reg_din_q    <= reg_din_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;
  assign reg_load = reg_load_q;
  assign reg_din  = reg_din_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed expected writes; a negedge monitor
// checks every hold cycle and every ack against the queue front.
module tb_regbank_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [5:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  ack;
  logic        err;
  logic        busy;
  logic [0:0]  grant_id;
  logic [5:0]  reg_load;
  logic [15:0] reg_din;

  regbank_write_arbiter #(
    .NUM_REQ(2), .NUM_REGS(6), .DATA_W(16), .HOLD_CYCLES(2)
  ) dut (
    .clkpos(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .err(err), .busy(busy), .grant_id(grant_id),
    .reg_load(reg_load), .reg_din(reg_din)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [5:0] load; logic [15:0] din; logic err; } exp_t;
  typedef struct { logic [2:0] a; logic [15:0] d; } wr_t;

  exp_t sb[$];
  wr_t  tbl[2][4];
  int   cnt[2];
  int   nxt[2];
  int   checks = 0;
  int   failures = 0;
  int   hold_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input int id, input logic [5:0] load, input logic [15:0] din, input logic e);
    exp_t x;
    x.id = id; x.load = load; x.din = din; x.err = e;
    sb.push_back(x);
  endtask

  task automatic set_wr(input int i, input int k, input logic [2:0] a, input logic [15:0] d);
    tbl[i][k].a = a;
    tbl[i][k].d = d;
  endtask

  task automatic apply();
    for (int i = 0; i < 2; i++) begin
      if (nxt[i] < cnt[i]) begin
        req[i]             = 1'b1;
        req_addr[i*3 +: 3]  = tbl[i][nxt[i]].a;
        req_data[i*16 +: 16] = tbl[i][nxt[i]].d;
      end else begin
        req[i] = 1'b0;
      end
    end
  endtask

  // Requesters re-request immediately after ack while table entries remain.
  task automatic drive(input int budget, output int first_ack, output int last_ack);
    int total, seen, cyc;
    total = cnt[0] + cnt[1];
    seen = 0; cyc = 0; first_ack = -1; last_ack = -1;
    nxt[0] = 0; nxt[1] = 0;
    apply();
    while (seen < total && cyc < budget) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          nxt[i]++;
          seen++;
          if (first_ack < 0) first_ack = cyc;
          last_ack = cyc;
        end
      end
      @(posedge clk); #1;
      apply();
    end
    chk("drive_done", seen, total);
  endtask

  task automatic wait_ack(input int i, input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!ack[i] && c < budget);
    chk("ack_wait", 32'(ack[i]), 1);
    @(posedge clk); #1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_cnt = 0;
      end else begin
        chk("onehot", 32'($countones(reg_load) <= 1), 1);
        if (ack != 2'b00) begin
          if (sb.size() == 0) begin
            chk("unexpected_ack", 32'(ack), 0);
          end else begin
            e = sb.pop_front();
            $display("ack: id=%0d err=%0b din=%h holds=%0d", grant_id, err, reg_din, hold_cnt);
            chk("ack_vec", 32'(ack), 32'(2'b01 << e.id));
            chk("ack_err", 32'(err), 32'(e.err));
            chk("ack_gid", 32'(grant_id), 32'(e.id));
            chk("ack_load", 32'(reg_load), 0);
            chk("hold_len", hold_cnt, 2);
          end
          hold_cnt = 0;
        end else if (busy) begin
          if (sb.size() == 0) begin
            chk("unexpected_busy", 32'(busy), 0);
          end else begin
            chk("hold_load", 32'(reg_load), 32'(sb[0].load));
            chk("hold_din", 32'(reg_din), 32'(sb[0].din));
            chk("hold_gid", 32'(grant_id), 32'(sb[0].id));
          end
          hold_cnt++;
        end
      end
    end
  end

  initial begin
    int fa, la;
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load", 32'(reg_load), 0);
    chk("rst_din", 32'(reg_din), 0);
    chk("rst_gid", 32'(grant_id), 0);
    rst = 1'b0;

    // Single write, latency HOLD_CYCLES+2
    cnt[0] = 1; cnt[1] = 0;
    set_wr(0, 0, 3'd3, 16'hA5A5);
    push(0, 6'b001000, 16'hA5A5, 1'b0);
    drive(20, fa, la);
    chk("latency", fa, 4);
    chk("busy_after", 32'(busy), 0);

    // Simultaneous requests straight after reset: requester 0 first
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    cnt[0] = 1; cnt[1] = 1;
    set_wr(0, 0, 3'd1, 16'h1111);
    set_wr(1, 0, 3'd2, 16'h2222);
    push(0, 6'b000010, 16'h1111, 1'b0);
    push(1, 6'b000100, 16'h2222, 1'b0);
    drive(30, fa, la);

    // Continuous contention: grants alternate, one write per 4 cycles
    cnt[0] = 3; cnt[1] = 3;
    set_wr(0, 0, 3'd0, 16'h0A00); set_wr(0, 1, 3'd1, 16'h0A01); set_wr(0, 2, 3'd2, 16'h0A02);
    set_wr(1, 0, 3'd3, 16'h0B00); set_wr(1, 1, 3'd4, 16'h0B01); set_wr(1, 2, 3'd5, 16'h0B02);
    push(0, 6'b000001, 16'h0A00, 1'b0);
    push(1, 6'b001000, 16'h0B00, 1'b0);
    push(0, 6'b000010, 16'h0A01, 1'b0);
    push(1, 6'b010000, 16'h0B01, 1'b0);
    push(0, 6'b000100, 16'h0A02, 1'b0);
    push(1, 6'b100000, 16'h0B02, 1'b0);
    drive(60, fa, la);
    chk("contention_last_ack", la, 24);

    // Data and address change after grant are ignored
    req[0] = 1'b1; req_addr[2:0] = 3'd2; req_data[15:0] = 16'h1234;
    push(0, 6'b000100, 16'h1234, 1'b0);
    @(posedge clk); #1;
    req_data[15:0] = 16'hFFFF; req_addr[2:0] = 3'd5;
    wait_ack(0, 10);
    req[0] = 1'b0;

    // Out-of-range addresses 7 and 6, then a normal write
    cnt[0] = 1; cnt[1] = 2;
    set_wr(1, 0, 3'd7, 16'h7777); set_wr(1, 1, 3'd4, 16'h4444);
    set_wr(0, 0, 3'd6, 16'h6666);
    push(1, 6'b000000, 16'h7777, 1'b1);
    push(0, 6'b000000, 16'h6666, 1'b1);
    push(1, 6'b010000, 16'h4444, 0);
    drive(40, fa, la);

    // Reset in the second HOLD cycle aborts, then re-grant once rst falls
    req[0] = 1'b1; req_addr[2:0] = 3'd1; req_data[15:0] = 16'hBEEF;
    push(0, 6'b000010, 16'hBEEF, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_load", 32'(reg_load), 0);
    chk("abort_ack", 32'(ack), 0);
    chk("abort_busy", 32'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("regrant_busy", 32'(busy), 1);
    chk("regrant_gid", 32'(grant_id), 0);
    chk("regrant_load", 32'(reg_load), 32'(6'b000010));
    wait_ack(0, 10);
    req[0] = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
